// File: rtl/pipeline_mem_pkg.sv
// Shared definitions for the memory-access stage: FSM states, alignment mask, default timeout.
package pipeline_mem_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [1:0] ALIGN_MASK  = 2'b11;
  localparam int         DEF_TIMEOUT = 16;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) == 2'b00;
  endfunction
endpackage

// File: rtl/pipeline_mem_mux2.sv
// Generic two-input result mux.
module mux2 #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/pipeline_mem_timeout_ctr.sv
// BUSY-cycle counter for bus-transfer abort; only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (en && !expired)  cnt <= cnt + CW'(1);
  end

  assign expired = (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/pipeline_mem.sv
// Memory-access stage: req/ack word loads/stores, upstream stall, MEM/WB register.
// Optional bus timeout/abort enabled with `define MEM_TIMEOUT_EN.
module pipeline_mem
  import pipeline_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              memtoreg,
  input  logic              regwrite,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] memwritedata,
  input  logic [4:0]        writereg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [31:0]       dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [4:0]        wb_writereg,
  output logic [DATA_W-1:0] wb_result,
  output logic              misalign,
  output logic              buserr
);
  state_t            state_q;
  logic              cap_memtoreg, cap_regwrite;
  logic [4:0]        cap_writereg;
  logic              memop, aligned, start, expired;
  logic [DATA_W-1:0] done_result;

  assign memop   = ex_valid & (memread | memwrite);
  assign aligned = word_aligned(aluout[1:0]);
  assign start   = (state_q == IDLE) & memop & aligned;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start),
    .en      ((state_q == BUSY) & ~dmem_ack),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // Gated by reset so the upstream stall releases the instant reset asserts.
  assign mem_stall = reset_n & ((state_q == IDLE) ? start : (~dmem_ack & ~expired));

  // Captured address lives in dmem_addr, which is held for the whole transfer.
  mux2 #(.W(DATA_W)) u_res_mux (
    .sel (cap_memtoreg),
    .a   (DATA_W'(dmem_addr)),
    .b   (dmem_rdata),
    .y   (done_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      cap_memtoreg <= 1'b0;
      cap_regwrite <= 1'b0;
      cap_writereg <= '0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_writereg  <= '0;
      wb_result    <= '0;
      misalign     <= 1'b0;
      buserr       <= 1'b0;
    end else begin
      misalign <= 1'b0;
      buserr   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (memop && !aligned) begin
            misalign    <= 1'b1;
            wb_valid    <= 1'b1;
            wb_regwrite <= 1'b0;
            wb_writereg <= writereg;
            wb_result   <= aluout;
          end else if (memop) begin
            state_q      <= BUSY;
            dmem_req     <= 1'b1;
            dmem_we      <= memwrite;
            dmem_addr    <= 32'(aluout);
            dmem_wdata   <= memwritedata;
            cap_memtoreg <= memtoreg;
            cap_regwrite <= regwrite;
            cap_writereg <= writereg;
            wb_valid     <= 1'b0;
          end else begin
            wb_valid    <= ex_valid;
            wb_regwrite <= ex_valid & regwrite;
            wb_writereg <= writereg;
            wb_result   <= aluout;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state_q     <= IDLE;
            dmem_req    <= 1'b0;
            wb_valid    <= 1'b1;
            wb_regwrite <= cap_regwrite & ~dmem_we;
            wb_writereg <= cap_writereg;
            wb_result   <= done_result;
          end else if (expired) begin
            state_q     <= IDLE;
            dmem_req    <= 1'b0;
            buserr      <= 1'b1;
            wb_valid    <= 1'b1;
            wb_regwrite <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_mem.sv
// Scoreboard bench for pipeline_mem: driver pushes expected writebacks, monitor pops on each accepted slot.
module tb_pipeline_mem;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 0, reset_n = 0;
  logic          ex_valid, memread, memwrite, memtoreg, regwrite;
  logic [DW-1:0] aluout, memwritedata;
  logic [4:0]    writereg;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [31:0]   dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          mem_stall, wb_valid, wb_regwrite, misalign, buserr;
  logic [4:0]    wb_writereg;
  logic [DW-1:0] wb_result;

  pipeline_mem #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .regwrite(regwrite), .aluout(aluout), .memwritedata(memwritedata),
    .writereg(writereg), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg),
    .wb_result(wb_result), .misalign(misalign), .buserr(buserr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, rw, mis, berr, chk;
    logic [4:0]  rg;
    logic [31:0] res;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] bus_mem   [logic [31:0]];
  int          force_wait = -1, last_wait = 0, cur_wait = 0, wleft = -1;
  bit          no_ack = 0, mon_on = 1, pend = 0;
  logic [31:0] c_addr, c_wd;
  logic        c_we;

  function automatic logic [31:0] deflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory responder: random (or forced) wait states, checks request stability.
  initial begin
    dmem_ack = 0; dmem_rdata = 0;
    forever begin
      @(negedge clk);
      dmem_ack   = 0;
      dmem_rdata = $urandom;
      if (!reset_n || !dmem_req) wleft = -1;
      else if (!no_ack) begin
        if (wleft < 0) begin
          wleft    = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
          cur_wait = wleft;
          c_addr = dmem_addr; c_we = dmem_we; c_wd = dmem_wdata;
        end else begin
          chk("addr_stable", dmem_addr, c_addr);
          chk("we_stable", 32'(dmem_we), 32'(c_we));
          chk("wdata_stable", dmem_wdata, c_wd);
        end
        if (wleft == 0) begin
          dmem_ack  = 1;
          last_wait = cur_wait;
          if (dmem_we) bus_mem[dmem_addr] = dmem_wdata;
          else dmem_rdata = bus_mem.exists(dmem_addr) ? bus_mem[dmem_addr] : deflt(dmem_addr);
          wleft = -1;
        end else wleft--;
      end
    end
  end

  // Monitor: every cycle the stage is not stalling, the following edge produces one writeback slot.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (mon_on && pend) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wb_slot: got output slot expected none queued (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("wb_valid", 32'(wb_valid), 32'(e.valid));
          chk("wb_regwrite", 32'(wb_regwrite), 32'(e.rw));
          chk("misalign", 32'(misalign), 32'(e.mis));
          chk("buserr", 32'(buserr), 32'(e.berr));
          if (e.chk) begin
            chk("wb_writereg", 32'(wb_writereg), 32'(e.rg));
            chk("wb_result", wb_result, e.res);
          end
        end
      end
      pend = reset_n && !mem_stall;
    end
  end

  // Present one instruction, hold it while stalled, push the spec-level expected writeback.
  task automatic issue(input logic v, rd, wr, m2r, rw, input logic [31:0] alu, wd,
                       input logic [4:0] rg, input bit exp_to);
    exp_t e;
    int   held, exp_held;
    logic memop;
    ex_valid = v; memread = rd; memwrite = wr; memtoreg = m2r; regwrite = rw;
    aluout = alu; memwritedata = wd; writereg = rg;
    memop = v & (rd | wr);
    e.valid = 0; e.rw = 0; e.mis = 0; e.berr = 0; e.chk = 0; e.rg = rg; e.res = alu;
    if (!memop) begin
      e.valid = v; e.rw = v & rw; e.chk = 1; exp_held = 1;
    end else if (alu[1:0] != 2'b00) begin
      e.valid = 1; e.mis = 1; exp_held = 1;
    end else if (exp_to) begin
      e.valid = 1; e.berr = 1; exp_held = TO + 1;
    end else begin
      e.valid = 1; e.rw = rw & ~wr; e.chk = 1; exp_held = -1;
      if (wr) model_mem[alu] = wd;
      else if (m2r) e.res = model_mem.exists(alu) ? model_mem[alu] : deflt(alu);
    end
    held = 0;
    do begin
      @(negedge clk); #1;
      held++;
    end while (mem_stall && held < 60);
    if (mem_stall) begin
      n_cmp++; n_bad++;
      $display("FAIL stall_bound: got stall after %0d cycles expected release", held);
    end
    if (exp_held < 0) exp_held = last_wait + 2;
    chk("held_cycles", 32'(held), 32'(exp_held));
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      issue(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0);
      chk("no_req_idle", 32'(dmem_req), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [31:0] a;
    ex_valid = 0; memread = 0; memwrite = 0; memtoreg = 0; regwrite = 0;
    aluout = 0; memwritedata = 0; writereg = 0;
    #3;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_result", wb_result, 32'd0);
    @(posedge clk); @(posedge clk); #3;
    reset_n = 1;

    // directed cases
    issue(1, 0, 0, 0, 1, 32'h10, 32'h0, 5'd5, 0);
    bus_mem[32'h100] = 32'hDEADBEEF; model_mem[32'h100] = 32'hDEADBEEF;
    force_wait = 0;
    issue(1, 1, 0, 1, 1, 32'h100, 32'h0, 5'd7, 0);
    force_wait = 3;
    issue(1, 0, 1, 0, 1, 32'h104, 32'h12345678, 5'd3, 0);
    force_wait = -1;
    issue(1, 1, 0, 1, 1, 32'h104, 32'h0, 5'd9, 0);
    issue(1, 1, 0, 1, 1, 32'h102, 32'h0, 5'd4, 0);
    chk("misalign_no_req", 32'(dmem_req), 32'd0);

`ifdef MEM_TIMEOUT_EN
    no_ack = 1;
    issue(1, 1, 0, 1, 1, 32'h108, 32'h0, 5'd6, 1);
    chk("timeout_req_drop", 32'(dmem_req), 32'd0);
    no_ack = 0;
    idle(1);
`endif

    // random mix
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 99);
      a = 32'h100 + 32'($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (k < 10)      issue(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), a, $urandom, 5'($urandom), 0);
      else if (k < 40) issue(1, 0, 0, 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom), 0);
      else if (k < 70) issue(1, 1, 0, 1'($urandom), 1'($urandom), a, $urandom, 5'($urandom), 0);
      else if (k < 95) issue(1, 0, 1, 0, 1'($urandom), a, $urandom, 5'($urandom), 0);
      else             issue(1, 1, 1, 0, 1'($urandom), a, $urandom, 5'($urandom), 0);
    end

    // reset in the middle of a transfer
    no_ack = 1;
    ex_valid = 1; memread = 1; memwrite = 0; memtoreg = 1; regwrite = 1;
    aluout = 32'h110; writereg = 5'd2;
    @(posedge clk); @(posedge clk); #1;
    chk("busy_req", 32'(dmem_req), 32'd1);
    #1 reset_n = 0;
    #1;
    chk("midrst_req", 32'(dmem_req), 32'd0);
    chk("midrst_stall", 32'(mem_stall), 32'd0);
    chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst_wb_regwrite", 32'(wb_regwrite), 32'd0);
    chk("midrst_wb_writereg", 32'(wb_writereg), 32'd0);
    chk("midrst_wb_result", wb_result, 32'd0);
    ex_valid = 0; memread = 0; memtoreg = 0; regwrite = 0; aluout = 0; writereg = 0;
    no_ack = 0;
    @(posedge clk); #3;
    reset_n = 1;
    idle(3);
    issue(1, 0, 0, 0, 1, 32'hCAFE0000, 32'h0, 5'd31, 0);

    ex_valid = 0;
    @(negedge clk); #2;
    mon_on = 0;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
